grad_mag_sqrt: RTL and testbench

Streaming gradient-magnitude stage for the camera-to-HDMI pixel pipeline.
- Takes signed Sobel gradients (gx, gy) per pixel and computes gx²+gy².
- Scales and saturates the sum into an 8-bit address, drives the external rom_sqrt lookup and consumes its read data as the 8-bit magnitude.
- Thresholds the magnitude into an edge flag, carries video sync alongside the data, and counts edge pixels per frame.

---
 rtl/pixelbox_edge_pkg.sv | 29 ++
 rtl/grad_sq_sat.sv | 49 ++++
 rtl/grad_mag_sqrt.sv | 112 +++++++++++
 tb/tb_grad_mag_sqrt.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pixelbox_edge_pkg.sv
// Shared widths, sideband bundle and address saturation for the gradient-magnitude stage.
package pixelbox_edge_pkg;

  localparam int GRAD_W   = 11;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int SUM_W    = 2 * GRAD_W;
  localparam int ROM_LAT  = 1;
  localparam int PIPE_LAT = 3 + ROM_LAT;

  typedef struct packed {
    logic vld;
    logic de;
    logic hs;
    logic vs;
  } side_t;

  // Scale the energy down and clamp it to the last ROM entry.
  function automatic logic [ADDR_W-1:0] sat_addr(input logic [SUM_W-1:0] sum,
                                                 input int unsigned      shift);
    logic [SUM_W-1:0] shifted;
    shifted = sum >> shift;
    if (shifted > SUM_W'((1 << ADDR_W) - 1)) begin
      return {ADDR_W{1'b1}};
    end
    return shifted[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/grad_sq_sat.sv
// Absolute value, squared-sum and saturated ROM address generation (S1-S2).
module grad_sq_sat
  import pixelbox_edge_pkg::*;
#(
  parameter int SQ_SHIFT = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [GRAD_W-1:0] i_gx,
  input  logic signed [GRAD_W-1:0] i_gy,
  output logic        [ADDR_W-1:0] o_rom_addr
);

  // Two's-complement negate of -2^(GRAD_W-1) yields the exact unsigned magnitude.
  function automatic logic [GRAD_W-1:0] abs_u(input logic signed [GRAD_W-1:0] v);
    return v[GRAD_W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  logic [GRAD_W-1:0] r_ax_p0;
  logic [GRAD_W-1:0] r_ay_p0;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [SUM_W-1:0]  w_sum;

  // S1: magnitudes of both gradients
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ax_p0 <= '0;
      r_ay_p0 <= '0;
    end else begin
      r_ax_p0 <= abs_u(i_gx);
      r_ay_p0 <= abs_u(i_gy);
    end
  end

  assign w_sum = SUM_W'(r_ax_p0) * SUM_W'(r_ax_p0)
               + SUM_W'(r_ay_p0) * SUM_W'(r_ay_p0);

  // S2: scaled, saturated ROM address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_p1 <= '0;
    end else begin
      r_addr_p1 <= sat_addr(w_sum, SQ_SHIFT);
    end
  end

  assign o_rom_addr = r_addr_p1;

endmodule

// File: rtl/grad_mag_sqrt.sv
// Gradient magnitude via external sqrt ROM, edge threshold, sideband delay and per-frame edge count.
module grad_mag_sqrt
  import pixelbox_edge_pkg::*;
#(
  parameter int SQ_SHIFT = 13,
  parameter int THRESH   = 64,
  parameter int CNT_W    = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [GRAD_W-1:0] in_gx,
  input  logic signed [GRAD_W-1:0] in_gy,
  input  logic                     in_de,
  input  logic                     in_hs,
  input  logic                     in_vs,
  output logic        [ADDR_W-1:0] rom_addr,
  input  logic        [DATA_W-1:0] rom_data,
  output logic                     out_valid,
  output logic        [DATA_W-1:0] out_mag,
  output logic                     out_edge,
  output logic                     out_de,
  output logic                     out_hs,
  output logic                     out_vs,
  output logic        [CNT_W-1:0]  frame_edge_cnt,
  output logic                     frame_cnt_vld
);

  side_t             w_side_in;
  side_t             r_side_p0;
  side_t             r_side_p1;
  side_t             r_side_p2;
  side_t             r_side_p3;
  logic [DATA_W-1:0] r_mag_p3;
  logic              r_edge_p3;
  logic [CNT_W-1:0]  r_run_cnt;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic              r_frame_vld;
  logic              r_vs_prev;
  logic              w_pix;
  logic              w_vs_rise;

  grad_sq_sat #(
    .SQ_SHIFT (SQ_SHIFT)
  ) u_sq (
    .clk        (clk),
    .rst        (rst),
    .i_gx       (in_gx),
    .i_gy       (in_gy),
    .o_rom_addr (rom_addr)
  );

  assign w_side_in = '{vld: in_valid, de: in_de, hs: in_hs, vs: in_vs};

  // S1..S4: sideband delay line, free-running and aligned with the magnitude
  always_ff @(posedge clk) begin
    if (rst) begin
      r_side_p0 <= '0;
      r_side_p1 <= '0;
      r_side_p2 <= '0;
      r_side_p3 <= '0;
    end else begin
      r_side_p0 <= w_side_in;
      r_side_p1 <= r_side_p0;
      r_side_p2 <= r_side_p1;
      r_side_p3 <= r_side_p2;
    end
  end

  // S4: capture ROM output, masked by the aligned valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag_p3  <= '0;
      r_edge_p3 <= 1'b0;
    end else begin
      r_mag_p3  <= r_side_p2.vld ? rom_data : '0;
      r_edge_p3 <= r_side_p2.vld & (rom_data >= DATA_W'(THRESH));
    end
  end

  assign w_pix     = r_side_p3.vld & r_side_p3.de & r_edge_p3;
  assign w_vs_rise = r_side_p3.vs & ~r_vs_prev;

  // Frame counter: a pixel coincident with the vsync rise opens the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cnt   <= '0;
      r_frame_cnt <= '0;
      r_frame_vld <= 1'b0;
      r_vs_prev   <= 1'b0;
    end else begin
      r_vs_prev   <= r_side_p3.vs;
      r_frame_vld <= w_vs_rise;
      if (w_vs_rise) begin
        r_frame_cnt <= r_run_cnt;
        r_run_cnt   <= {{(CNT_W-1){1'b0}}, w_pix};
      end else if (w_pix && (r_run_cnt != {CNT_W{1'b1}})) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
    end
  end

  assign out_valid      = r_side_p3.vld;
  assign out_de         = r_side_p3.de;
  assign out_hs         = r_side_p3.hs;
  assign out_vs         = r_side_p3.vs;
  assign out_mag        = r_mag_p3;
  assign out_edge       = r_edge_p3;
  assign frame_edge_cnt = r_frame_cnt;
  assign frame_cnt_vld  = r_frame_vld;

endmodule

// File: tb/tb_grad_mag_sqrt.sv
// Scoreboard bench for grad_mag_sqrt with a behavioural 1-cycle sqrt ROM.
module tb_grad_mag_sqrt;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [10:0] in_gx = '0;
  logic signed [10:0] in_gy = '0;
  logic               in_de = 1'b0;
  logic               in_hs = 1'b0;
  logic               in_vs = 1'b0;
  logic [7:0]         rom_addr;
  logic [7:0]         rom_data = '0;
  logic               out_valid;
  logic [7:0]         out_mag;
  logic               out_edge;
  logic               out_de;
  logic               out_hs;
  logic               out_vs;
  logic [21:0]        frame_edge_cnt;
  logic               frame_cnt_vld;

  grad_mag_sqrt dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_gx          (in_gx),
    .in_gy          (in_gy),
    .in_de          (in_de),
    .in_hs          (in_hs),
    .in_vs          (in_vs),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .out_valid      (out_valid),
    .out_mag        (out_mag),
    .out_edge       (out_edge),
    .out_de         (out_de),
    .out_hs         (out_hs),
    .out_vs         (out_vs),
    .frame_edge_cnt (frame_edge_cnt),
    .frame_cnt_vld  (frame_cnt_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] mag;
    logic       edg;
    logic [7:0] addr;
  } exp_t;

  exp_t        q[$];
  int unsigned pulses[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned m_run    = 0;
  int unsigned m_frame  = 0;
  logic        m_fvld   = 1'b0;
  logic        m_vs_prev = 1'b0;

  function automatic int rom_val(input int a);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= 256 * a) r++;
    return r;
  endfunction

  always @(posedge clk) rom_data <= 8'(rom_val(int'(rom_addr)));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(input logic v, input int gx, input int gy,
                                    input logic de, input logic hs, input logic vs);
    exp_t e;
    int ax, ay, s, a, m;
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    s  = ax * ax + ay * ay;
    a  = s >> 13;
    if (a > 255) a = 255;
    m  = rom_val(a);
    e.vld  = v;
    e.de   = de;
    e.hs   = hs;
    e.vs   = vs;
    e.addr = 8'(a);
    e.mag  = v ? 8'(m) : 8'd0;
    e.edg  = v && (m >= 64);
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    if (frame_cnt_vld === 1'b1) pulses.push_back(int'(frame_edge_cnt));
    if (q.size() >= 2) check_eq("rom_addr", 32'(rom_addr), 32'(q[q.size()-2].addr));
    if (q.size() >= 4) begin
      e = q.pop_front();
      check_eq("out_valid", 32'(out_valid), 32'(e.vld));
      check_eq("out_de",    32'(out_de),    32'(e.de));
      check_eq("out_hs",    32'(out_hs),    32'(e.hs));
      check_eq("out_vs",    32'(out_vs),    32'(e.vs));
      check_eq("out_mag",   32'(out_mag),   32'(e.mag));
      check_eq("out_edge",  32'(out_edge),  32'(e.edg));
      check_eq("frame_edge_cnt", 32'(frame_edge_cnt), 32'(m_frame));
      check_eq("frame_cnt_vld",  32'(frame_cnt_vld),  32'(m_fvld));
      if (e.vs && !m_vs_prev) begin
        m_frame = m_run;
        m_fvld  = 1'b1;
        m_run   = (e.vld && e.de && e.edg) ? 1 : 0;
      end else begin
        m_fvld = 1'b0;
        if (e.vld && e.de && e.edg && m_run != 32'h3F_FFFF) m_run++;
      end
      m_vs_prev = e.vs;
    end
  endtask

  task automatic step(input logic v, input int gx, input int gy,
                      input logic de, input logic hs, input logic vs, input logic r);
    exp_t z;
    @(negedge clk);
    monitor();
    rst      = r;
    in_valid = v;
    in_gx    = 11'(gx);
    in_gy    = 11'(gy);
    in_de    = de;
    in_hs    = hs;
    in_vs    = vs;
    if (r) begin
      z = make_exp(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      q.delete();
      repeat (4) q.push_back(z);
      m_run = 0; m_frame = 0; m_fvld = 1'b0; m_vs_prev = 1'b0;
    end else begin
      q.push_back(make_exp(v, gx, gy, de, hs, vs));
    end
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, vs, 1'b0);
  endtask

  initial begin
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    step(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 300, -400, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, -1024, -1024, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 100, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1023, 1023, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 300, -400, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);

    for (int i = 0; i < 48; i++) begin
      step(1'($urandom_range(0, 1)),
           int'($urandom_range(0, 2047)) - 1024,
           int'($urandom_range(0, 2047)) - 1024,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           (i % 16) >= 12, 1'b0);
    end
    idle(6, 1'b0);

    pulses.delete();
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    idle(2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 1 && i < 9) step(1'b1, 100, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      else                     step(1'b1, 300, -400, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, -1024, -1024, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    idle(2, 1'b0);
    step(1'b1, 300, -400, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 700, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8, 1'b1);
    check_eq("n_frame_pulses", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      check_eq("frame_cnt_a", pulses[1], 32'd7);
      check_eq("frame_cnt_b", pulses[2], 32'd3);
    end

    step(1'b1, 300, -400, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, -1024, -1024, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 300, 400, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 300, -400, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_frame_cnt", 32'(frame_edge_cnt), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    idle(6, 1'b0);
    step(1'b1, 100, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
